axi3_sram_responder: RTL and testbench

- AXI3 slave memory model. It answers the CPU-side AXI master: AR/R channels on one side, AW/W/B channels on the other.
- Used as the instruction/data backing store in standalone simulation and FPGA bring-up of the core, in place of the SoC interconnect.
- Read and write engines are independent FSMs sharing one word-addressed byte-writable RAM.

---
 rtl/axi3_sram_responder_if.sv | 69 ++++++
 rtl/axi3_sram_responder.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_axi3_sram_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi3_sram_responder_if.sv
// AXI3 bus bundle between the CPU-side master and the SRAM responder.
interface axi3_sram_responder_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi3_sram_responder.sv
// AXI3 slave memory model: independent read/write engines over one byte-writable word RAM.
// Optional random back-pressure is enabled with the macro AXI3_SRAM_RESPONDER_STALL_EN.
module axi3_sram_responder #(
    parameter int MEM_AW    = 12,
    parameter     INIT_FILE = ""
) (
    input  logic                  clock,
    input  logic                  reset,
    axi3_sram_responder_if.slave  io_axi
);
    localparam int         MEM_WORDS   = 1 << MEM_AW;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {R_IDLE, R_BEAT} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [MEM_WORDS];

    function automatic logic req_unsupported(input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'd2) || (burst[1] == 1'b1);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == 2'b01) ? addr + (32'd1 << size) : addr;
    endfunction

    logic init_r;
    logic stall_s;
    logic unused_ok_s;

    assign unused_ok_s = ^{io_axi.arlock, io_axi.arcache, io_axi.arprot,
                           io_axi.awlock, io_axi.awcache, io_axi.awprot};

    // Init flag marks the first cycle out of reset; no request is taken before it
    always_ff @(posedge clock) begin
        if (reset) init_r <= 1'b0;
        else       init_r <= 1'b1;
    end

`ifdef AXI3_SRAM_RESPONDER_STALL_EN
    logic [15:0] lfsr_r;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 drives pseudo-random back-pressure
    always_ff @(posedge clock) begin
        if (reset) lfsr_r <= 16'hACE1;
        else       lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
    assign stall_s = lfsr_r[0];
`else
    assign stall_s = 1'b0;
`endif

    // ---------------- read engine ----------------
    r_state_t          r_state_r, r_state_s;
    logic [3:0]        r_id_r, r_id_s;
    logic [31:0]       r_addr_r, r_addr_s;
    logic [7:0]        r_len_r, r_len_s, r_cnt_r, r_cnt_s;
    logic [2:0]        r_size_r, r_size_s;
    logic [1:0]        r_burst_r, r_burst_s;
    logic              r_unsup_r, r_unsup_s;
    logic              arready_r, arready_s, rvalid_r, rvalid_s, rlast_r, rlast_s;
    logic [1:0]        rresp_r, rresp_s;
    logic [31:0]       rdata_r;
    logic              r_load_s;
    logic [MEM_AW-1:0] r_load_idx_s;
    logic              ar_fire_s, r_fire_s;

    assign ar_fire_s = io_axi.arvalid & arready_r & init_r;
    assign r_fire_s  = rvalid_r & io_axi.rready;

    // Read FSM next-state; rdata is fetched on AR and on every non-last beat handshake
    always_comb begin
        r_state_s    = r_state_r;
        r_id_s       = r_id_r;
        r_addr_s     = r_addr_r;
        r_len_s      = r_len_r;
        r_cnt_s      = r_cnt_r;
        r_size_s     = r_size_r;
        r_burst_s    = r_burst_r;
        r_unsup_s    = r_unsup_r;
        arready_s    = 1'b0;
        rvalid_s     = rvalid_r;
        rlast_s      = rlast_r;
        rresp_s      = rresp_r;
        r_load_s     = 1'b0;
        r_load_idx_s = r_addr_r[MEM_AW+1:2];
        case (r_state_r)
            R_IDLE: begin
                if (ar_fire_s) begin
                    r_state_s    = R_BEAT;
                    r_id_s       = io_axi.arid;
                    r_addr_s     = io_axi.araddr;
                    r_len_s      = io_axi.arlen;
                    r_size_s     = io_axi.arsize;
                    r_burst_s    = io_axi.arburst;
                    r_unsup_s    = req_unsupported(io_axi.arsize, io_axi.arburst);
                    r_cnt_s      = 8'd0;
                    rvalid_s     = ~stall_s;
                    rlast_s      = (io_axi.arlen == 8'd0);
                    rresp_s      = r_unsup_s ? RESP_SLVERR : RESP_OKAY;
                    r_load_s     = 1'b1;
                    r_load_idx_s = io_axi.araddr[MEM_AW+1:2];
                end else begin
                    arready_s = ~stall_s;
                end
            end
            R_BEAT: begin
                if (r_fire_s) begin
                    if (r_cnt_r == r_len_r) begin
                        r_state_s = R_IDLE;
                        rvalid_s  = 1'b0;
                        rlast_s   = 1'b0;
                        arready_s = ~stall_s;
                    end else begin
                        r_cnt_s      = r_cnt_r + 8'd1;
                        r_addr_s     = next_addr(r_addr_r, r_size_r, r_burst_r);
                        rvalid_s     = ~stall_s;
                        rlast_s      = (r_cnt_s == r_len_r);
                        r_load_s     = 1'b1;
                        r_load_idx_s = r_addr_s[MEM_AW+1:2];
                    end
                end else begin
                    // a beat already on the bus stays put until it is taken
                    rvalid_s = rvalid_r | ~stall_s;
                end
            end
            default: begin
                r_state_s = R_IDLE;
            end
        endcase
    end

    // Read FSM state and R-channel output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_r <= R_IDLE;
            r_id_r    <= 4'd0;
            r_addr_r  <= 32'd0;
            r_len_r   <= 8'd0;
            r_cnt_r   <= 8'd0;
            r_size_r  <= 3'd0;
            r_burst_r <= 2'd0;
            r_unsup_r <= 1'b0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rresp_r   <= 2'd0;
        end else begin
            r_state_r <= r_state_s;
            r_id_r    <= r_id_s;
            r_addr_r  <= r_addr_s;
            r_len_r   <= r_len_s;
            r_cnt_r   <= r_cnt_s;
            r_size_r  <= r_size_s;
            r_burst_r <= r_burst_s;
            r_unsup_r <= r_unsup_s;
            arready_r <= arready_s;
            rvalid_r  <= rvalid_s;
            rlast_r   <= rlast_s;
            rresp_r   <= rresp_s;
        end
    end

    // Read data register: sampled before the same-edge write lands (read-first)
    always_ff @(posedge clock) begin
        if (reset)         rdata_r <= 32'd0;
        else if (r_load_s) rdata_r <= r_unsup_s ? 32'd0 : mem[r_load_idx_s];
    end

    // ---------------- write engine ----------------
    w_state_t    w_state_r, w_state_s;
    logic [3:0]  w_id_r, w_id_s;
    logic [31:0] w_addr_r, w_addr_s;
    logic [7:0]  w_len_r, w_len_s, w_cnt_r, w_cnt_s;
    logic [2:0]  w_size_r, w_size_s;
    logic [1:0]  w_burst_r, w_burst_s;
    logic        w_unsup_r, w_unsup_s, w_err_r, w_err_s;
    logic        awready_r, awready_s, wready_r, wready_s, bvalid_r, bvalid_s;
    logic [1:0]  bresp_r, bresp_s;
    logic        mem_we_s;
    logic        aw_fire_s, w_fire_s, b_fire_s;

    assign aw_fire_s = io_axi.awvalid & awready_r & init_r;
    assign w_fire_s  = io_axi.wvalid & wready_r;
    assign b_fire_s  = bvalid_r & io_axi.bready;

    // Write FSM next-state; the beat count, not wlast, decides where a burst ends
    always_comb begin
        w_state_s = w_state_r;
        w_id_s    = w_id_r;
        w_addr_s  = w_addr_r;
        w_len_s   = w_len_r;
        w_cnt_s   = w_cnt_r;
        w_size_s  = w_size_r;
        w_burst_s = w_burst_r;
        w_unsup_s = w_unsup_r;
        w_err_s   = w_err_r;
        awready_s = 1'b0;
        wready_s  = 1'b0;
        bvalid_s  = bvalid_r;
        bresp_s   = bresp_r;
        mem_we_s  = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (aw_fire_s) begin
                    w_state_s = W_DATA;
                    w_id_s    = io_axi.awid;
                    w_addr_s  = io_axi.awaddr;
                    w_len_s   = io_axi.awlen;
                    w_size_s  = io_axi.awsize;
                    w_burst_s = io_axi.awburst;
                    w_unsup_s = req_unsupported(io_axi.awsize, io_axi.awburst);
                    w_cnt_s   = 8'd0;
                    w_err_s   = 1'b0;
                    wready_s  = ~stall_s;
                end else begin
                    awready_s = ~stall_s;
                end
            end
            W_DATA: begin
                if (w_fire_s) begin
                    mem_we_s = ~w_unsup_r;
                    w_err_s  = w_err_r | (io_axi.wlast != (w_cnt_r == w_len_r))
                                       | (io_axi.wid != w_id_r);
                    if (w_cnt_r == w_len_r) begin
                        w_state_s = W_RESP;
                        bvalid_s  = ~stall_s;
                        bresp_s   = (w_err_s | w_unsup_r) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_cnt_s  = w_cnt_r + 8'd1;
                        w_addr_s = next_addr(w_addr_r, w_size_r, w_burst_r);
                        wready_s = ~stall_s;
                    end
                end else begin
                    wready_s = ~stall_s;
                end
            end
            W_RESP: begin
                if (b_fire_s) begin
                    w_state_s = W_IDLE;
                    bvalid_s  = 1'b0;
                    awready_s = ~stall_s;
                end else begin
                    bvalid_s = bvalid_r | ~stall_s;
                end
            end
            default: begin
                w_state_s = W_IDLE;
            end
        endcase
    end

    // Write FSM state and AW/W/B output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_r <= W_IDLE;
            w_id_r    <= 4'd0;
            w_addr_r  <= 32'd0;
            w_len_r   <= 8'd0;
            w_cnt_r   <= 8'd0;
            w_size_r  <= 3'd0;
            w_burst_r <= 2'd0;
            w_unsup_r <= 1'b0;
            w_err_r   <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'd0;
        end else begin
            w_state_r <= w_state_s;
            w_id_r    <= w_id_s;
            w_addr_r  <= w_addr_s;
            w_len_r   <= w_len_s;
            w_cnt_r   <= w_cnt_s;
            w_size_r  <= w_size_s;
            w_burst_r <= w_burst_s;
            w_unsup_r <= w_unsup_s;
            w_err_r   <= w_err_s;
            awready_r <= awready_s;
            wready_r  <= wready_s;
            bvalid_r  <= bvalid_s;
            bresp_r   <= bresp_s;
        end
    end

    // Byte-lane RAM write; contents survive reset, only the reset cycle's beat is dropped
    always_ff @(posedge clock) begin
        if (mem_we_s && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (io_axi.wstrb[i]) mem[w_addr_r[MEM_AW+1:2]][8*i +: 8] <= io_axi.wdata[8*i +: 8];
            end
        end
    end

    assign io_axi.arready = arready_r;
    assign io_axi.rid     = r_id_r;
    assign io_axi.rdata   = rdata_r;
    assign io_axi.rresp   = rresp_r;
    assign io_axi.rlast   = rlast_r;
    assign io_axi.rvalid  = rvalid_r;
    assign io_axi.awready = awready_r;
    assign io_axi.wready  = wready_r;
    assign io_axi.bid     = w_id_r;
    assign io_axi.bresp   = bresp_r;
    assign io_axi.bvalid  = bvalid_r;
endmodule

// File: tb/tb_axi3_sram_responder.sv
// Self-checking bench for axi3_sram_responder: directed plan steps plus randomized bursts
// checked against a word-array reference model of the memory.
module tb_axi3_sram_responder;
    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    axi3_sram_responder_if bus ();

    axi3_sram_responder #(.MEM_AW(12), .INIT_FILE("")) dut (
        .clock  (clock),
        .reset  (reset),
        .io_axi (bus)
    );

    logic [31:0] ref_mem [4096];
    logic [31:0] wq_data [$];
    logic [3:0]  wq_strb [$];
    logic        wq_last [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // byte address of beat i: FIXED stays, INCR steps by 2^size with 32-bit wrap
    function automatic logic [31:0] beat_addr(input logic [31:0] addr, input int i,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step;
        step = 32'd1 << size;
        return (burst == 2'b00) ? addr : addr + 32'(i) * step;
    endfunction

    task automatic push_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        wq_data.push_back(d);
        wq_strb.push_back(s);
        wq_last.push_back(l);
    endtask

    task automatic idle_bus();
        bus.arid = 4'd0; bus.araddr = 32'd0; bus.arlen = 8'd0; bus.arsize = 3'd0;
        bus.arburst = 2'd0; bus.arlock = 2'd0; bus.arcache = 4'd0; bus.arprot = 3'd0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awid = 4'd0; bus.awaddr = 32'd0; bus.awlen = 8'd0; bus.awsize = 3'd0;
        bus.awburst = 2'd0; bus.awlock = 2'd0; bus.awcache = 4'd0; bus.awprot = 3'd0;
        bus.awvalid = 1'b0;
        bus.wid = 4'd0; bus.wdata = 32'd0; bus.wstrb = 4'd0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [3:0] wid);
        int          cyc;
        logic        hs;
        logic        done;
        logic        unsup;
        logic        err;
        logic [31:0] a;
        unsup = (size > 3'd2) || burst[1];
        err   = unsup || (wid != id);
        for (int i = 0; i <= int'(len); i++) if (wq_last[i] != (i == int'(len))) err = 1'b1;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awlock = 2'($urandom); bus.awcache = 4'($urandom); bus.awprot = 3'($urandom);
        bus.awvalid = 1'b1;
        cyc = 0;
        do begin hs = bus.awready; @(posedge clock); #1; cyc++; end while (!hs && cyc < 50);
        bus.awvalid = 1'b0;
        check("aw_handshake", 64'(hs), 64'd1);
        for (int i = 0; i <= int'(len); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.wvalid = 1'b0;
                @(posedge clock); #1;
            end
            bus.wid = wid; bus.wdata = wq_data[i]; bus.wstrb = wq_strb[i]; bus.wlast = wq_last[i];
            bus.wvalid = 1'b1;
            cyc = 0;
            do begin hs = bus.wready; @(posedge clock); #1; cyc++; end while (!hs && cyc < 50);
            bus.wvalid = 1'b0;
            check("w_handshake", 64'(hs), 64'd1);
            if (!unsup) begin
                a = beat_addr(addr, i, size, burst);
                for (int b = 0; b < 4; b++)
                    if (wq_strb[i][b]) ref_mem[a[13:2]][8*b +: 8] = wq_data[i][8*b +: 8];
            end
        end
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 50) begin
            bus.bready = 1'($urandom_range(0, 1));
            if (bus.bvalid) begin
                check("bid", 64'(bus.bid), 64'(id));
                check("bresp", 64'(bus.bresp), err ? 64'd2 : 64'd0);
                if (bus.bready) done = 1'b1;
            end
            @(posedge clock); #1;
            cyc++;
        end
        bus.bready = 1'b0;
        check("b_handshake", 64'(done), 64'd1);
        wq_data.delete(); wq_strb.delete(); wq_last.delete();
    endtask

    // mode 0: rready always 1, 1: toggling 1,0,1,.., 2: random; stop_at < 0 runs the full burst
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode,
                            input int stop_at);
        int          cyc;
        int          beat;
        logic        hs;
        logic        rr;
        logic        tog;
        logic        unsup;
        logic [31:0] a;
        logic [31:0] exp_data;
        unsup = (size > 3'd2) || burst[1];
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arlock = 2'($urandom); bus.arcache = 4'($urandom); bus.arprot = 3'($urandom);
        bus.arvalid = 1'b1;
        cyc = 0;
        do begin hs = bus.arready; @(posedge clock); #1; cyc++; end while (!hs && cyc < 50);
        bus.arvalid = 1'b0;
        check("ar_handshake", 64'(hs), 64'd1);
        beat = 0;
        cyc  = 0;
        tog  = 1'b1;
        while (beat <= int'(len) && beat != stop_at && cyc < 300) begin
            case (mode)
                0:       rr = 1'b1;
                1:       rr = tog;
                default: rr = 1'($urandom_range(0, 1));
            endcase
            tog = ~tog;
            bus.rready = rr;
            a        = beat_addr(addr, beat, size, burst);
            exp_data = unsup ? 32'd0 : ref_mem[a[13:2]];
            check("rvalid", 64'(bus.rvalid), 64'd1);
            check("rdata", 64'(bus.rdata), 64'(exp_data));
            check("rresp", 64'(bus.rresp), unsup ? 64'd2 : 64'd0);
            check("rlast", 64'(bus.rlast), 64'(beat == int'(len)));
            check("rid", 64'(bus.rid), 64'(id));
            check("arready_busy", 64'(bus.arready), 64'd0);
            if (rr) beat++;
            @(posedge clock); #1;
            cyc++;
        end
        bus.rready = 1'b0;
        check("r_beats", 64'(beat), (stop_at < 0) ? 64'(int'(len) + 1) : 64'(stop_at));
        if (stop_at < 0) begin
            check("rvalid_after", 64'(bus.rvalid), 64'd0);
            check("arready_after", 64'(bus.arready), 64'd1);
        end
    endtask

    initial begin
        logic [3:0]  rid_v;
        logic [31:0] raddr_v;
        logic [7:0]  rlen_v;
        idle_bus();
        for (int i = 0; i < 4096; i++) ref_mem[i] = 32'd0;

        // reset held for three cycles, then released
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("reset_ctrl", 64'({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.rlast,
                  bus.bvalid, bus.rid, bus.rresp, bus.bid, bus.bresp}), 64'd0);
            check("reset_rdata", 64'(bus.rdata), 64'd0);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        check("arready_post_reset", 64'(bus.arready), 64'd1);
        check("awready_post_reset", 64'(bus.awready), 64'd1);

        // four-beat INCR write and toggled-rready readback
        push_beat(32'h11, 4'hF, 1'b0); push_beat(32'h22, 4'hF, 1'b0);
        push_beat(32'h33, 4'hF, 1'b0); push_beat(32'h44, 4'hF, 1'b1);
        axi_write(4'd3, 32'h100, 8'd3, 3'd2, 2'b01, 4'd3);
        axi_read(4'd5, 32'h100, 8'd3, 3'd2, 2'b01, 1, -1);

        // byte strobes merge into existing word
        push_beat(32'hAABBCCDD, 4'hF, 1'b1);
        axi_write(4'd1, 32'h100, 8'd0, 3'd2, 2'b01, 4'd1);
        push_beat(32'h11223344, 4'b0101, 1'b1);
        axi_write(4'd2, 32'h100, 8'd0, 3'd2, 2'b01, 4'd2);
        axi_read(4'd6, 32'h100, 8'd0, 3'd2, 2'b01, 0, -1);

        // early wlast: both beats still written, SLVERR
        push_beat(32'hDEAD0001, 4'hF, 1'b1); push_beat(32'hDEAD0002, 4'hF, 1'b0);
        axi_write(4'd7, 32'h180, 8'd1, 3'd2, 2'b01, 4'd7);
        axi_read(4'd7, 32'h180, 8'd1, 3'd2, 2'b01, 0, -1);
        // wid mismatch
        push_beat(32'hCAFEF00D, 4'hF, 1'b1);
        axi_write(4'd4, 32'h190, 8'd0, 3'd2, 2'b01, 4'd9);
        // unsupported size: RAM untouched, SLVERR
        push_beat(32'h0BAD0BAD, 4'hF, 1'b1);
        axi_write(4'd8, 32'h180, 8'd0, 3'd3, 2'b01, 4'd8);
        axi_read(4'd8, 32'h180, 8'd1, 3'd2, 2'b01, 2, -1);
        // WRAP read returns zero data with SLVERR
        axi_read(4'd9, 32'h100, 8'd1, 3'd2, 2'b10, 0, -1);
        // upper address bits alias onto the same words
        axi_read(4'd10, 32'h0001_0100, 8'd3, 3'd2, 2'b01, 2, -1);
        // FIXED burst keeps rewriting one word
        push_beat(32'h01010101, 4'hF, 1'b0); push_beat(32'h02020202, 4'b0011, 1'b0);
        push_beat(32'h03030303, 4'b1000, 1'b1);
        axi_write(4'd11, 32'h200, 8'd2, 3'd2, 2'b00, 4'd11);
        axi_read(4'd11, 32'h200, 8'd2, 3'd2, 2'b00, 2, -1);
        // 32-bit address wrap from the top of the space
        push_beat(32'hF00DFACE, 4'hF, 1'b0); push_beat(32'h5EED5EED, 4'hF, 1'b1);
        axi_write(4'd12, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 4'd12);
        axi_read(4'd12, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 0, -1);

        // reset in the middle of a read burst, then a clean read
        axi_read(4'd5, 32'h100, 8'd3, 3'd2, 2'b01, 0, 2);
        reset = 1'b1;
        @(posedge clock); #1;
        check("mid_reset_rvalid", 64'(bus.rvalid), 64'd0);
        check("mid_reset_arready", 64'(bus.arready), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("mid_reset_arready_after", 64'(bus.arready), 64'd1);
        axi_read(4'd5, 32'h100, 8'd3, 3'd2, 2'b01, 0, -1);

        // randomized traffic over a prefilled 1 KiB window
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) push_beat($urandom, 4'hF, i == 15);
            rid_v = 4'($urandom);
            axi_write(rid_v, 32'(b * 64), 8'd15, 3'd2, 2'b01, rid_v);
        end
        for (int n = 0; n < 40; n++) begin
            rid_v   = 4'($urandom);
            raddr_v = 32'($urandom_range(0, 32'h3C0));
            rlen_v  = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i <= int'(rlen_v); i++)
                    push_beat($urandom, 4'($urandom), i == int'(rlen_v));
                axi_write(rid_v, raddr_v, rlen_v, 3'($urandom_range(0, 2)),
                          2'($urandom_range(0, 1)), rid_v);
            end else begin
                axi_read(rid_v, raddr_v, rlen_v, 3'($urandom_range(0, 2)),
                         2'($urandom_range(0, 1)), 2, -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
